kmeans_in_framer: RTL

- Upstream input stage of the k-means core. Parses the raw 16-bit `in_valid`/`in_data` stream from the pattern or host into a header, point records and initial centroids.
- Points are buffered in a FIFO and presented to the clustering datapath through a valid/ready handshake.
- The input stream has no backpressure, so the block absorbs rate mismatch and flags overflow.

---
 rtl/kmeans_pkg.sv | 31 +++
 rtl/kmeans_sync_fifo.sv | 53 +++++
 rtl/kmeans_in_framer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared constants, header field positions and FSM encoding for the k-means input framer.
// Build option: KM_CHECKSUM_EN adds the CSUM state for a trailing frame checksum word.
package kmeans_pkg;

    localparam int COORD_W = 8;
    localparam int MAX_K   = 8;
    localparam int PT_W    = 2 * COORD_W;

    localparam int HDR_N_MSB = 15;
    localparam int HDR_N_LSB = 8;
    localparam int HDR_K_MSB = 3;
    localparam int HDR_K_LSB = 0;

`ifdef KM_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POINTS,
        ST_CENTS,
        ST_CSUM,
        ST_DRAIN
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POINTS,
        ST_CENTS,
        ST_DRAIN
    } state_t;
`endif

endpackage

// File: rtl/kmeans_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head taken from flop storage;
// a push when full is accepted only if a pop frees the slot in the same cycle.
module kmeans_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/kmeans_in_framer.sv
// Parses the raw k-means input stream into header, buffered points and initial centroids.
// Build option: KM_CHECKSUM_EN checks a trailing modulo-2^16 sum word after the centroids.
module kmeans_in_framer
    import kmeans_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [15:0]     in_data,
    output logic            cfg_valid,
    output logic [7:0]      cfg_n,
    output logic [3:0]      cfg_k,
    output logic            cen_valid,
    output logic [2:0]      cen_idx,
    output logic [15:0]     cen_data,
    output logic            pt_valid,
    input  logic            pt_ready,
    output logic [PT_W-1:0] pt_data,
    output logic            pt_last,
    output logic            frame_done,
    output logic            err
);

    state_t      state, state_n;
    logic [7:0]  n_reg;
    logic [3:0]  k_reg;
    logic [7:0]  cnt;
    logic        skip;
    logic        last_gone;

    logic [7:0]  hdr_n;
    logic [3:0]  hdr_k;
    logic        at_last_pt;
    logic        at_last_cen;

    logic        push, flush, pop, overflow;
    logic        hdr_load, hdr_bad, cen_load;
    logic        cnt_inc, cnt_clr, set_err, done;

    logic [PT_W:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    assign hdr_n       = in_data[HDR_N_MSB:HDR_N_LSB];
    assign hdr_k       = in_data[HDR_K_MSB:HDR_K_LSB];
    assign at_last_pt  = (cnt == n_reg - 8'd1);
    assign at_last_cen = (cnt == {4'b0, k_reg} - 8'd1);

    assign pop      = pt_ready && !fifo_empty;
    assign overflow = push && fifo_full && !pop;

    // Head is zeroed while empty so the port reads 0 after reset or flush.
    assign pt_valid = !fifo_empty;
    assign pt_data  = pt_valid ? fifo_head[PT_W-1:0] : '0;
    assign pt_last  = pt_valid && fifo_head[PT_W];

`ifdef KM_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk) begin
        if (hdr_load)
            sum <= in_data;
        else if (push || cen_load)
            sum <= sum + in_data;
    end
`endif

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        flush    = 1'b0;
        hdr_load = 1'b0;
        hdr_bad  = 1'b0;
        cen_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        set_err  = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && !skip) begin
                    if (hdr_n == 8'd0 || hdr_k == 4'd0 || hdr_k > 4'(MAX_K)) begin
                        hdr_bad = 1'b1;
                    end else begin
                        hdr_load = 1'b1;
                        cnt_clr  = 1'b1;
                        state_n  = ST_POINTS;
                    end
                end
            end
            ST_POINTS: begin
                if (!in_valid) begin
                    set_err = 1'b1;
                    flush   = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    push    = 1'b1;
                    cnt_inc = 1'b1;
                    if (at_last_pt) begin
                        cnt_clr = 1'b1;
                        state_n = ST_CENTS;
                    end
                end
            end
            ST_CENTS: begin
                if (!in_valid) begin
                    set_err = 1'b1;
                    flush   = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cen_load = 1'b1;
                    cnt_inc  = 1'b1;
                    if (at_last_cen) begin
                        cnt_clr = 1'b1;
`ifdef KM_CHECKSUM_EN
                        state_n = ST_CSUM;
`else
                        state_n = ST_DRAIN;
`endif
                    end
                end
            end
`ifdef KM_CHECKSUM_EN
            ST_CSUM: begin
                if (!in_valid) begin
                    set_err = 1'b1;
                    flush   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    set_err = (in_data != sum);
                    state_n = ST_DRAIN;
                end
            end
`endif
            ST_DRAIN: begin
                set_err = in_valid;
                if (last_gone && fifo_empty) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_reg      <= '0;
            k_reg      <= '0;
            cnt        <= '0;
            skip       <= 1'b0;
            last_gone  <= 1'b0;
            cfg_valid  <= 1'b0;
            cfg_n      <= '0;
            cfg_k      <= '0;
            cen_valid  <= 1'b0;
            cen_idx    <= '0;
            cen_data   <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_valid  <= hdr_load;
            cen_valid  <= cen_load;
            frame_done <= done;

            if (hdr_load) begin
                n_reg <= hdr_n;
                k_reg <= hdr_k;
                cfg_n <= hdr_n;
                cfg_k <= hdr_k;
            end

            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 8'd1;

            // A bad header blanks the rest of its burst so payload words are never taken as headers.
            if (hdr_bad)
                skip <= 1'b1;
            else if (!in_valid)
                skip <= 1'b0;

            if (cen_load) begin
                cen_idx  <= cnt[2:0];
                cen_data <= in_data;
            end

            if (hdr_load)
                err <= 1'b0;
            else if (hdr_bad || set_err || overflow)
                err <= 1'b1;

            // A dropped final point also counts as gone, otherwise DRAIN would never finish.
            if (hdr_load || flush || done)
                last_gone <= 1'b0;
            else if ((pop && fifo_head[PT_W]) || (overflow && at_last_pt))
                last_gone <= 1'b1;
        end
    end

    kmeans_sync_fifo #(
        .WIDTH (PT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({at_last_pt, in_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
